// File: rtl/phase_stats.sv
// phase_stats: windowed sum/min/max of phase detector counts with a valid/ready result slot
module phase_stats #(
  parameter int LOG2N = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stop_in,
  input  logic [7:0]         phase_diff,
  input  logic               enable,
  input  logic               clear,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [8+LOG2N-1:0] out_sum,
  output logic [7:0]         out_mean,
  output logic [7:0]         out_min,
  output logic [7:0]         out_max,
  output logic               out_sat,
  output logic               overrun
);
  localparam int SW = 8 + LOG2N;
  // LOG2N = 0 still needs a one-bit counter; it never leaves zero since every sample completes
  localparam int CW = LOG2N > 0 ? LOG2N : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2N) - 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t          state;
  logic            stop_q;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   acc_sum;
  logic [7:0]      acc_min, acc_max;
  logic            acc_sat;
  logic            ev, done, slot_free;
  logic [SW-1:0]   nsum;
  logic [7:0]      nmin, nmax;
  logic            nsat;
  // next-accumulator values including the sample on the event cycle
  always_comb begin
    ev        = stop_in && !stop_q && enable;
    done      = ev && cnt == LAST;
    slot_free = !out_valid || out_ready;
    nsum      = acc_sum + SW'(phase_diff);
    nmin      = phase_diff < acc_min ? phase_diff : acc_min;
    nmax      = phase_diff > acc_max ? phase_diff : acc_max;
    nsat      = acc_sat || phase_diff == 8'hFF;
  end
  assign out_mean = 8'(out_sum >> LOG2N);
  // edge detect, accumulation FSM and the single-entry result slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      stop_q    <= 1'b0;
      cnt       <= '0;
      acc_sum   <= '0;
      acc_min   <= 8'hFF;
      acc_max   <= 8'h00;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_min   <= 8'h00;
      out_max   <= 8'h00;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      stop_q <= stop_in;
      state  <= enable ? ACCUM : IDLE;
      if (clear) begin
        cnt       <= '0;
        acc_sum   <= '0;
        acc_min   <= 8'hFF;
        acc_max   <= 8'h00;
        acc_sat   <= 1'b0;
        out_valid <= 1'b0;
        out_sum   <= '0;
        out_min   <= 8'h00;
        out_max   <= 8'h00;
        out_sat   <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (done || (state == ACCUM && !enable)) begin
          cnt     <= '0;
          acc_sum <= '0;
          acc_min <= 8'hFF;
          acc_max <= 8'h00;
          acc_sat <= 1'b0;
        end else if (ev) begin
          cnt     <= cnt + CW'(1);
          acc_sum <= nsum;
          acc_min <= nmin;
          acc_max <= nmax;
          acc_sat <= nsat;
        end
        if (done && slot_free) begin
          out_valid <= 1'b1;
          out_sum   <= nsum;
          out_min   <= nmin;
          out_max   <= nmax;
          out_sat   <= nsat;
        end else if (done) begin
          overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/phase_stats.md
# phase_stats

Windowed statistics accumulator directly downstream of the phase detector, in the same fast clock domain. It samples the detector's 8-bit start-to-stop tick count once per completed measurement, on the rising edge of the echo (`stop`) signal. Over windows of 2^LOG2N measurements it accumulates sum, min and max. Each finished window is offered to the readout logic as one result record through a valid/ready handshake.

## Interface
- `LOG2N`, 4: log2 of samples per window; legal range 0..8.
- `clk`  in  1  fast counting clock, same clock as the phase detector.
- `rstn`  in  1  asynchronous active-low reset.
- `stop_in`  in  1  echo signal, the same net the phase detector receives as `stop`.
- `phase_diff`  in  8  phase detector count output.
- `enable`  in  1  level; high = accept measurements.
- `clear`  in  1  synchronous clear pulse.
- `out_ready`  in  1  consumer accepts result.
- `out_valid`  out  1  result record valid.
- `out_sum`  out  8+LOG2N  sum of window samples.
- `out_mean`  out  8  `out_sum >> LOG2N`, truncating.
- `out_min`  out  8  smallest sample in window.
- `out_max`  out  8  largest sample in window.
- `out_sat`  out  1  some sample in window equalled 255 (possible detector wrap).
- `overrun`  out  1  sticky: a window result was dropped.

## Operation
- `stop_q` register:
  - Tracks `stop_in` every cycle, regardless of `enable`.
  - Sample event = `stop_in && !stop_q && enable`.
  - On the event cycle `phase_diff` already holds the final count and is captured directly.
- States:
  - IDLE: `enable` = 0.
    - Sample count, accumulating sum, running min (0xFF), running max (0x00) and sat held at init values.
    - Output registers untouched.
  - ACCUM: `enable` = 1.
    - Each sample event: sum += sample; min/max updated; sat |= (sample == 255); count++.
    - Count is a LOG2N-bit counter plus a completion compare.
- Transitions:
  - IDLE→ACCUM when `enable` = 1.
  - ACCUM→IDLE when `enable` = 0; the partial window is discarded and accumulators reinit.
  - A stop edge coinciding with `enable` rise is counted.
  - `stop_in` already high when `enable` rises is not an edge.
- Window completion: the sample event bringing count to 2^LOG2N.
  - Final values include that sample.
  - Accumulators reinit on the same edge; the next window starts empty.
- Output slot is free when `!out_valid`, or when `out_valid && out_ready` on that cycle.
  - Completion with free slot: load `out_sum`/`out_min`/`out_max`/`out_sat` and set `out_valid`.
  - Completion with no free slot: result dropped, `overrun` set, held output unchanged.
- Handshake:
  - Transfer = `out_valid && out_ready` at a clock edge.
  - After a transfer, `out_valid` clears unless a new result loads on the same edge, in which case it stays 1 with new data.
  - Outputs are stable while `out_valid && !out_ready`.
- `out_mean` is combinational from `out_sum`.
- `clear` (highest synchronous priority):
  - Reinits accumulators and count; clears `out_valid` and `overrun`.
  - Output data registers go to 0.
  - A sample event on the same cycle is discarded.
- Widths: the sum cannot overflow (max 255·2^LOG2N fits 8+LOG2N bits).
- LOG2N = 0: every sample is its own window (sum = min = max = sample).

## Timing
- Reset (`rstn` low, async): `out_valid` 0, `out_sum`/`out_min`/`out_max` 0, `out_sat` 0, `overrun` 0, `stop_q` 0, state IDLE, accumulators at init values. Reset mid-window discards it.
- Latency: sample at edge k → `out_valid` high after edge k when k completes a window (1 cycle from the stop edge).
- Maximum sample rate: one per 2 cycles (stop must drop between events). Sample events on consecutive cycles are impossible by the edge rule.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- LOG2N=2; samples 10,20,30,40, `out_ready`=1 → one record: sum 100, mean 25, min 10, max 40, sat 0; `out_valid` high exactly 1 cycle.
- LOG2N=2; samples 5,255,7,9 → sum 276, mean 69, min 5, max 255, sat 1.
- LOG2N=0, `out_ready`=0; two stop edges (samples 3, then 8) → record holds 3; `overrun` = 1 after the second; `clear` → `overrun` 0, `out_valid` 0.
- LOG2N=2; 2 samples, `enable` low 1 cycle, then 4 samples of 50 → single record sum 200; earlier partial window absent.
- Back-to-back windows: completion on the same edge as a transfer → `out_valid` stays 1, data updates, no overrun.
- `stop_in` held high across `enable` rise → no sample; `rstn` low mid-window → all outputs 0 immediately (async).
